// File: rtl/demux4_stream_router.sv
// demux4_stream_router
// Registered, flow-controlled 1:4 stream demultiplexer. Each word on the input
// stream is steered by in_sel into one of four single-entry channel buffers.
// Every channel has its own valid/ready handshake, so a stalled consumer blocks
// only the words addressed to it. Words sent to a channel whose ch_en bit is
// clear are accepted and discarded, and the sticky drop_flag is raised.
//
// Optional build macro: DEMUX4_CNT_EN adds saturating per-channel accept
// counters and a drop counter (ports cnt_clr, cnt_out, drop_cnt).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   router can take the word this cycle (combinational)
//   in_sel     destination channel 0..3
//   in_data    upstream word
//   ch_en      per-channel enable mask, bit i = channel i
//   out_valid  bit i: channel i buffer holds a word
//   out_ready  bit i: consumer i takes the word this cycle
//   out_data   channel i word at [i*DATA_W +: DATA_W]
//   drop_flag  sticky: a word was addressed to a disabled channel
//   drop_clr   synchronous clear of drop_flag (a same-edge drop wins)
//   cnt_clr    (DEMUX4_CNT_EN) synchronous clear of all counters
//   cnt_out    (DEMUX4_CNT_EN) channel i accept count at [i*CNT_W +: CNT_W]
//   drop_cnt   (DEMUX4_CNT_EN) dropped-word count
module demux4_stream_router #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [3:0]            ch_en,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic                  drop_flag,
  input  logic                  drop_clr
`ifdef DEMUX4_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [4*CNT_W-1:0]    cnt_out,
  output logic [CNT_W-1:0]      drop_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("demux4_stream_router: DATA_W and CNT_W must be at least 1");
  end

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } buf_state_e;

  buf_state_e        state_q [4];
  buf_state_e        state_d [4];
  logic [DATA_W-1:0] data_q  [4];
  logic              drop_flag_q;
  logic              drop_flag_d;

  logic              sel_en;
  logic              accept;
  logic              drop;
  logic [3:0]        wr_en;

  // Disabled channels act as a sink, so the stream never stalls on them.
  always_comb begin
    sel_en   = ch_en[in_sel];
    in_ready = 1'b1;
    if (sel_en) begin
      in_ready = (state_q[in_sel] == StEmpty) | out_ready[in_sel];
    end
    accept = in_valid & in_ready;
    drop   = accept & ~sel_en;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_en[i]   = accept & sel_en & (in_sel == 2'(i));
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StEmpty: begin
          if (wr_en[i]) state_d[i] = StFull;
        end
        StFull: begin
          // A same-edge reload keeps the buffer full: no bubble.
          if (wr_en[i])          state_d[i] = StFull;
          else if (out_ready[i]) state_d[i] = StEmpty;
        end
        default: state_d[i] = StEmpty;
      endcase
    end
  end

  always_comb begin
    drop_flag_d = drop_flag_q;
    if (drop)          drop_flag_d = 1'b1;
    else if (drop_clr) drop_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StEmpty;
        data_q[i]  <= '0;
      end
      drop_flag_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        // Data only moves on accept; an emptied buffer keeps its last word.
        if (wr_en[i]) data_q[i] <= in_data;
      end
      drop_flag_q <= drop_flag_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < 4; i++) begin
      out_valid[i]                  = (state_q[i] == StFull);
      out_data[i*DATA_W +: DATA_W]  = data_q[i];
    end
    drop_flag = drop_flag_q;
  end

`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] drop_cnt_q;

  // Counters saturate at all-ones; clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < 4; i++) cnt_out[i*CNT_W +: CNT_W] = cnt_q[i];
    drop_cnt = drop_cnt_q;
  end
`endif

endmodule

// File: tb/tb_demux4_stream_router.sv
// Self-checking bench for demux4_stream_router: directed steps followed by a
// randomized phase, all compared against a per-channel behavioural model.
module tb_demux4_stream_router;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 2;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_sel;
  logic [DATA_W-1:0]   in_data;
  logic [3:0]          ch_en;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
  logic                drop_flag;
  logic                drop_clr;
  logic                cnt_clr;
`ifdef DEMUX4_CNT_EN
  logic [4*CNT_W-1:0]  cnt_out;
  logic [CNT_W-1:0]    drop_cnt;
`endif

  demux4_stream_router #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_flag (drop_flag),
    .drop_clr  (drop_clr)
`ifdef DEMUX4_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt_out   (cnt_out),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: contents of each channel buffer, sticky flag, counters.
  logic              m_valid [4];
  logic [DATA_W-1:0] m_data  [4];
  logic              m_flag;
  int                m_cnt   [4];
  int                m_dcnt;
  int                cnt_max;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_cnt[i]   = 0;
    end
    m_flag = 1'b0;
    m_dcnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]          ev;
    logic [4*DATA_W-1:0] ed;
    for (int i = 0; i < 4; i++) begin
      ev[i]                     = m_valid[i];
      ed[i*DATA_W +: DATA_W]    = m_data[i];
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".out_data"},  64'(out_data),  64'(ed));
    chk({tag, ".drop_flag"}, 64'(drop_flag), 64'(m_flag));
`ifdef DEMUX4_CNT_EN
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".cnt_out"}, 64'(cnt_out[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
    end
    chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_dcnt));
`endif
  endtask

  // One clock: drive, check just before the edge, then advance the model.
  task automatic cyc(input string tag, input logic v, input logic [1:0] s,
                     input logic [DATA_W-1:0] d, input logic [3:0] en,
                     input logic [3:0] ordy, input logic dclr, input logic cclr);
    logic exp_rdy;
    logic acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    ch_en     = en;
    out_ready = ordy;
    drop_clr  = dclr;
    cnt_clr   = cclr;
    @(negedge clk);
    check_outputs(tag);
    exp_rdy = en[s] ? (!m_valid[s] || ordy[s]) : 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    for (int i = 0; i < 4; i++) begin
      if (acc && en[s] && (int'(s) == i)) begin
        m_valid[i] = 1'b1;
        m_data[i]  = d;
        if (!cclr && m_cnt[i] < cnt_max) m_cnt[i]++;
      end else if (m_valid[i] && ordy[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (acc && !en[s]) begin
      m_flag = 1'b1;
      if (!cclr && m_dcnt < cnt_max) m_dcnt++;
    end else if (dclr) begin
      m_flag = 1'b0;
    end
    if (cclr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_dcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    cnt_max  = (1 << CNT_W) - 1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 2'd0;
    in_data  = '0;
    ch_en    = 4'hF;
    out_ready = 4'hF;
    drop_clr = 1'b0;
    cnt_clr  = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Route A0..A3 to channels 0..3 with all consumers ready.
    for (int i = 0; i < 4; i++) begin
      cyc("route", 1'b1, 2'(i), 8'hA0 + 8'(i), 4'hF, 4'hF, 1'b0, 1'b0);
    end
    cyc("route_tail", 1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b0, 1'b0);

    // Channel 2 stalls; channel 1 still flows; reload with no bubble.
    cyc("stall0", 1'b1, 2'd2, 8'h55, 4'hF, 4'b1011, 1'b0, 1'b0);
    cyc("stall1", 1'b1, 2'd2, 8'h66, 4'hF, 4'b1011, 1'b0, 1'b0);
    cyc("stall2", 1'b1, 2'd1, 8'h11, 4'hF, 4'b1011, 1'b0, 1'b0);
    cyc("stall3", 1'b1, 2'd2, 8'h66, 4'hF, 4'b1111, 1'b0, 1'b0);
    cyc("stall4", 1'b0, 2'd2, 8'h00, 4'hF, 4'b1111, 1'b0, 1'b0);

    // Drops on a masked channel; clear loses to a same-edge drop.
    cyc("drop0", 1'b1, 2'd2, 8'h77, 4'b1011, 4'hF, 1'b0, 1'b0);
    cyc("drop1", 1'b1, 2'd2, 8'h78, 4'b1011, 4'hF, 1'b1, 1'b0);
    cyc("drop2", 1'b0, 2'd2, 8'h00, 4'b1011, 4'hF, 1'b1, 1'b0);
    cyc("drop3", 1'b0, 2'd2, 8'h00, 4'b1011, 4'hF, 1'b0, 1'b0);

    // Mask change while full: buffered word still drains.
    cyc("mask0", 1'b1, 2'd0, 8'h3C, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc("mask1", 1'b0, 2'd0, 8'h00, 4'hE, 4'h0, 1'b0, 1'b0);
    cyc("mask2", 1'b0, 2'd0, 8'h00, 4'hE, 4'h1, 1'b0, 1'b0);

    // Counter saturation then clear (counters exist only with the macro).
    for (int i = 0; i < 5; i++) begin
      cyc("cnt", 1'b1, 2'd0, 8'(i), 4'hF, 4'hF, 1'b0, 1'b0);
    end
    cyc("cnt_clr", 1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b0, 1'b1);
    cyc("cnt_post", 1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b0, 1'b0);

    // Back-to-back stream to channel 3.
    for (int i = 0; i < 16; i++) begin
      cyc("b2b", 1'b1, 2'd3, 8'hC0 + 8'(i), 4'hF, 4'h8, 1'b0, 1'b0);
    end
    cyc("b2b_tail", 1'b0, 2'd3, 8'h00, 4'hF, 4'h8, 1'b0, 1'b0);

    // Fill all buffers, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) begin
      cyc("fill", 1'b1, 2'(i), 8'h90 + 8'(i), 4'hF, 4'h0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cyc("rand", 1'($urandom), 2'($urandom), 8'($urandom), en, 4'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
